// File: rtl/dcache_arbiter.sv
// Registered round-robin arbiter with burst limit for the 16x8 data cache port.
// Optional DCACHE_ARB_STRICT_PRIO_EN: fixed priority 0>1>2 with loader preemption.
module dcache_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req_in,
  input  logic [2:0]          wen_in,
  input  logic [3*ADDR_W-1:0] addr_in,
  input  logic [3*DATA_W-1:0] wdata_in,
  output logic [2:0]          gnt_out,
  output logic [1:0]          owner_out,
  output logic                busy_out,
  output logic [ADDR_W-1:0]   mem_addr_out,
  output logic [DATA_W-1:0]   mem_wdata_out,
  output logic                mem_wen_out,
  input  logic [DATA_W-1:0]   mem_rdata_in,
  output logic [DATA_W-1:0]   rdata_out
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [3:0] MAX = 4'(MAX_BURST);

  state_t     state, state_nx;
  logic [2:0] gnt_nx;
  logic [1:0] owner_nx;
  logic [1:0] rr_ptr, rr_nx;
  logic [3:0] cnt, cnt_nx;
  logic [2:0] others;
  logic [2:0] win;
  logic       own_req;
  logic       forced;

  // First requester at or after start, wrapping mod 3; one-hot result.
  function automatic logic [2:0] pick(input logic [2:0] req,
                                      input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    idx = start;
    for (int k = 0; k < 3; k++) begin
      if (res == 3'b000 && req[idx]) res[idx] = 1'b1;
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return res;
  endfunction

  function automatic logic [1:0] idx_of(input logic [2:0] oh);
    if (oh[0])      return 2'd0;
    else if (oh[1]) return 2'd1;
    else if (oh[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_out   <= '0;
      owner_out <= 2'd3;
      cnt       <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nx;
      gnt_out   <= gnt_nx;
      owner_out <= owner_nx;
      cnt       <= cnt_nx;
      rr_ptr    <= rr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_out;
    owner_nx = owner_out;
    cnt_nx   = cnt;
    rr_nx    = rr_ptr;
    win      = '0;
    others   = req_in & ~gnt_out;
    own_req  = |(req_in & gnt_out);
    forced   = own_req && (cnt == MAX) && (|others);
    unique case (state)
      IDLE: begin
`ifdef DCACHE_ARB_STRICT_PRIO_EN
        win = pick(req_in, 2'd0);
`else
        win = pick(req_in, rr_ptr);
`endif
        if (|win) begin
          state_nx = OWN;
          gnt_nx   = win;
          owner_nx = idx_of(win);
          cnt_nx   = 4'd1;
        end
      end
      OWN: begin
`ifdef DCACHE_ARB_STRICT_PRIO_EN
        if (req_in[0] && !gnt_out[0]) begin
          gnt_nx   = 3'b001;
          owner_nx = 2'd0;
          cnt_nx   = 4'd1;
        end else
`endif
        if (own_req && !forced) begin
          cnt_nx = (|others) ? cnt + 4'd1 : 4'd1;
        end else begin
          rr_nx = (owner_out == 2'd2) ? 2'd0 : owner_out + 2'd1;
`ifdef DCACHE_ARB_STRICT_PRIO_EN
          // Released owner is excluded so a forced release always hands over.
          win = pick(others, 2'd0);
`else
          win = pick(req_in, rr_nx);
`endif
          if (|win) begin
            gnt_nx   = win;
            owner_nx = idx_of(win);
            cnt_nx   = 4'd1;
          end else begin
            state_nx = IDLE;
            gnt_nx   = '0;
            owner_nx = 2'd3;
            cnt_nx   = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy_out  = |gnt_out;
  assign rdata_out = mem_rdata_in;

  always_comb begin
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    mem_wen_out   = 1'b0;
    case (owner_out)
      2'd0, 2'd1, 2'd2: begin
        mem_addr_out  = addr_in[owner_out*ADDR_W +: ADDR_W];
        mem_wdata_out = wdata_in[owner_out*DATA_W +: DATA_W];
        mem_wen_out   = |(gnt_out & req_in & wen_in);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dcache_arbiter.md
Name: dcache_arbiter

Overview:
- Single-port arbiter for the 16x8 data cache.
- Shares the cache between three requesters: SPI loader (req 0), core exec/store path (req 1), readback/dump engine (req 2).
- Registered grant, round-robin fairness, bounded hold time (burst limit).
- Drives the cache's addr/data/wen directly. The cache read is combinational, so read data is valid in the same cycle the grant is active.

Parameters:
ADDR_W, 4, cache address width
DATA_W, 8, cache data width
MAX_BURST, 4, maximum consecutive granted cycles while another requester waits (legal range 1..15)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
req_in  input  3  request per requester; bit i = requester i
wen_in  input  3  write qualifier per requester (1 = write)
addr_in  input  3*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
wdata_in  input  3*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
gnt_out  output  3  one-hot registered grant
owner_out  output  2  index of the current owner; 2'b11 when none
busy_out  output  1  high while any grant is active
mem_addr_out  output  ADDR_W  cache address
mem_wdata_out  output  DATA_W  cache write data
mem_wen_out  output  1  cache write enable
mem_rdata_in  input  DATA_W  cache combinational read data
rdata_out  output  DATA_W  read data to requesters; valid when own gnt is high

Behaviour:
- Reset values (async, immediate):
  - gnt_out = 0, owner_out = 2'b11, busy_out = 0.
  - State IDLE, burst_cnt = 0, rr_ptr = 0.
  - Memory outputs are all 0 while no grant is active.
- States:
  - IDLE: no owner.
  - OWN: owner o holds a grant.
- Arbitration function:
  - Search order starts at rr_ptr: rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - Winner = first requester with req_in high.
- Transitions from IDLE:
  - Any req_in high → next cycle gnt_out[winner] = 1, state OWN, burst_cnt = 1.
  - Grant latency is therefore 1 cycle from req sampled high.
- OWN, while req_in[o] stays high:
  - If burst_cnt < MAX_BURST, or no other req is pending: keep the grant.
  - burst_cnt increments, saturating at MAX_BURST.
  - burst_cnt resets to 1 when no other requester is pending.
- OWN, release:
  - Release occurs when req_in[o] falls, or when burst_cnt == MAX_BURST with another req pending.
  - rr_ptr ← (o+1) mod 3.
  - The new winner is computed with the updated pointer in the same cycle. If one exists, the grant moves to it on the next edge with no bubble, and burst_cnt = 1. Otherwise go to IDLE.
  - A forcibly released owner whose req is still high is considered last in the search order.
- Memory port (combinational from registered owner):
  - mem_addr_out = addr of o; mem_wdata_out = wdata of o.
  - mem_wen_out = gnt_out[o] & req_in[o] & wen_in[o]. A dropped req in its grant cycle never writes.
  - No owner → all three memory outputs are 0.
- rdata_out = mem_rdata_in, unconditionally.
- Requester contract:
  - Hold req, wen, addr and wdata stable until gnt is seen.
  - Each granted cycle with req high performs exactly one access.
- Simultaneous events:
  - Owner drops req in the same cycle a new req arrives: the new req competes under the updated rr_ptr.
  - req and release in the same cycle for the same requester: that requester is considered last in the search order.
- Out-of-range index: owner_out is never 2'b11 while busy_out = 1.
- Mid-operation reset: the grant drops asynchronously; no mem_wen_out pulse may be produced after rst rises.

Optional Feature:
- Macro: DCACHE_ARB_STRICT_PRIO_EN.
- Defined:
  - Fixed priority 0 > 1 > 2; rr_ptr is unused.
  - A req_in[0] rising while another requester owns the port preempts it at the next edge, regardless of burst_cnt. The preempted requester simply loses gnt.
  - Lets the loader preempt the core while a program is downloaded.
- Undefined: round-robin with burst limit, exactly as above.

Test Plan:
1. Reset, then req_in = 3'b010 with wen = 1, addr1 = 4'h5, wdata1 = 8'hA7 → gnt_out = 3'b010 one cycle later, mem_wen_out = 1, mem_addr_out = 5, mem_wdata_out = 8'hA7; rdata_out = 8'hA7 on the following read.
2. req_in = 3'b111 held, MAX_BURST = 4 → grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,0… with no idle cycles between owners.
3. Single requester 2 held for 20 cycles, no others → gnt_out = 3'b100 continuously, owner_out = 2, never released.
4. Owner 1 drops req in the same cycle req0 rises → next cycle gnt_out = 3'b001; mem_wen_out stays 0 in the drop cycle.
5. rst asserted mid-burst with wen high → gnt_out, mem_wen_out and busy_out go 0 immediately (before the next clk edge); after release, the first req is granted in 1 cycle.
6. With DCACHE_ARB_STRICT_PRIO_EN: owner 2 mid-burst at burst_cnt = 1, req0 rises → gnt_out = 3'b001 next edge; without the macro, owner 2 keeps the grant until MAX_BURST is reached.
